// File: rtl/mux_scan_if.sv
// ============================================================
// mux_scan_if : frame handshake bundle between scan sequencer and consumer
// Rev 1.0
// ============================================================
`default_nettype none

interface mux_scan_if;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;

    modport master (
        output frame,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame,
        input  frame_valid,
        output frame_ready
    );
endinterface

`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
// ============================================================
// mux_scan_sequencer : steps a 4:1 mux through its channels and frames the samples
// Rev 1.0
// ============================================================
`default_nettype none

module mux_scan_sequencer #(
    parameter int SETTLE_CYC = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       start_i,
    input  wire logic       cont_i,
    input  wire logic       clr_ovr_i,
    input  wire logic       mux_out_i,
    output logic [1:0]      sel_o,
    output logic            busy_o,
    output logic            overrun_o,
    mux_scan_if.master      frm_if
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // With no settle time a scan goes straight to sampling.
    localparam state_t     c_SCAN_ENTRY = (SETTLE_CYC > 0) ? S_SETTLE : S_SAMPLE;
    localparam logic [3:0] c_CNT_LAST   = 4'(SETTLE_CYC - 1);

    state_t     state_q;
    logic [1:0] idx_q;
    logic [3:0] cnt_q;
    logic [3:0] frame_q;
    logic       valid_q;
    logic       ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            frame_q <= 4'd0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // A start seen outside IDLE only flags; set has priority over clear.
            if (start_i && (state_q != S_IDLE)) begin
                ovr_q <= 1'b1;
            end else if (clr_ovr_i) begin
                ovr_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        idx_q   <= 2'd0;
                        cnt_q   <= 4'd0;
                        state_q <= c_SCAN_ENTRY;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == c_CNT_LAST) begin
                        cnt_q   <= 4'd0;
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    frame_q[idx_q] <= mux_out_i;
                    if (idx_q != 2'd3) begin
                        idx_q   <= idx_q + 2'd1;
                        cnt_q   <= 4'd0;
                        state_q <= c_SCAN_ENTRY;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (frm_if.frame_ready) begin
                        valid_q <= 1'b0;
                        idx_q   <= 2'd0;
                        cnt_q   <= 4'd0;
                        state_q <= cont_i ? c_SCAN_ENTRY : S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sel_o              = idx_q;
    assign busy_o             = (state_q != S_IDLE);
    assign overrun_o          = ovr_q;
    assign frm_if.frame       = frame_q;
    assign frm_if.frame_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================
// tb_mux_scan_sequencer : bench for three sequencers with SETTLE_CYC 1, 0 and 3
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mux_scan_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      start = '0;
    logic [2:0]      cont  = '0;
    logic [2:0]      clr   = '0;
    logic [2:0]      ready = '0;
    logic [2:0][3:0] chan  = '0;

    logic [2:0][1:0] sel;
    logic [2:0][3:0] frm;
    logic [2:0]      fv;
    logic [2:0]      busy;
    logic [2:0]      ovr;

    mux_scan_if if0 ();
    mux_scan_if if1 ();
    mux_scan_if if2 ();

    assign if0.frame_ready = ready[0];
    assign if1.frame_ready = ready[1];
    assign if2.frame_ready = ready[2];
    assign frm[0] = if0.frame;
    assign frm[1] = if1.frame;
    assign frm[2] = if2.frame;
    assign fv[0]  = if0.frame_valid;
    assign fv[1]  = if1.frame_valid;
    assign fv[2]  = if2.frame_valid;

    mux_scan_sequencer #(.SETTLE_CYC(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .cont_i(cont[0]),
        .clr_ovr_i(clr[0]), .mux_out_i(chan[0][sel[0]]), .sel_o(sel[0]),
        .busy_o(busy[0]), .overrun_o(ovr[0]), .frm_if(if0)
    );
    mux_scan_sequencer #(.SETTLE_CYC(0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .cont_i(cont[1]),
        .clr_ovr_i(clr[1]), .mux_out_i(chan[1][sel[1]]), .sel_o(sel[1]),
        .busy_o(busy[1]), .overrun_o(ovr[1]), .frm_if(if1)
    );
    mux_scan_sequencer #(.SETTLE_CYC(3)) u_dut_s3 (
        .clk(clk), .rst_n(rst_n), .start_i(start[2]), .cont_i(cont[2]),
        .clr_ovr_i(clr[2]), .mux_out_i(chan[2][sel[2]]), .sel_o(sel[2]),
        .busy_o(busy[2]), .overrun_o(ovr[2]), .frm_if(if2)
    );

    int         checks = 0;
    int         errors = 0;
    logic [3:0] sb[$];

    typedef struct {
        int         k;
        logic [3:0] ch;
        logic [3:0] exp_frame;
        int         exp_lat;
    } vec_t;

    function automatic int settle_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts a scan on instance k and waits for frame_valid; optional start/clr pulse mid-scan.
    task automatic do_scan(input int k, input logic [3:0] ch, input logic [3:0] exp_frame,
                           input int exp_lat, input int pulse_at, input bit pulse_clr);
        int         n;
        bit         selbad;
        logic [3:0] exp;
        chan[k] = ch;
        sb.push_back(exp_frame);
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        n = 0;
        selbad = (sel[k] != 2'd0);
        while (!fv[k] && n < 200) begin
            if (n == pulse_at) begin
                start[k] = 1'b1;
                clr[k]   = pulse_clr;
            end
            @(posedge clk); #1;
            n++;
            start[k] = 1'b0;
            clr[k]   = 1'b0;
            if (!fv[k] && (int'(sel[k]) != n / (settle_of(k) + 1))) selbad = 1'b1;
        end
        check("latency", n, exp_lat);
        check("sel_trace", int'(selbad), 0);
        exp = sb.pop_front();
        check("frame", int'(frm[k]), int'(exp));
    endtask

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
        $fatal(1);
    end

    initial begin
        int  n;
        bit  bad;

        vecs[0] = '{k: 0, ch: 4'b1010, exp_frame: 4'b1010, exp_lat: 8};
        vecs[1] = '{k: 1, ch: 4'b1111, exp_frame: 4'b1111, exp_lat: 4};
        vecs[2] = '{k: 2, ch: 4'b1111, exp_frame: 4'b1111, exp_lat: 16};
        vecs[3] = '{k: 0, ch: 4'b0101, exp_frame: 4'b0101, exp_lat: 8};
        vecs[4] = '{k: 1, ch: 4'b0011, exp_frame: 4'b0011, exp_lat: 4};
        vecs[5] = '{k: 2, ch: 4'b1000, exp_frame: 4'b1000, exp_lat: 16};

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_state", int'({sel[k], frm[k], fv[k], busy[k], ovr[k]}), 0);
        end

        // One-shot scans with frame_ready already high.
        for (int i = 0; i < 6; i++) begin
            ready[vecs[i].k] = 1'b1;
            cont[vecs[i].k]  = 1'b0;
            do_scan(vecs[i].k, vecs[i].ch, vecs[i].exp_frame, vecs[i].exp_lat, -1, 1'b0);
            @(posedge clk); #1;
            check("oneshot_valid_drop", int'(fv[vecs[i].k]), 0);
            check("oneshot_idle", int'(busy[vecs[i].k]), 0);
        end

        // Backpressure: frame held for 5 cycles.
        ready[0] = 1'b0;
        do_scan(0, 4'b1100, 4'b1100, 8, -1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", int'({fv[0], frm[0]}), int'({1'b1, 4'b1100}));
        end
        ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake", int'(fv[0]), 0);
        check("bp_idle", int'(busy[0]), 0);

        // Continuous mode on the zero-settle instance.
        ready[1] = 1'b1;
        cont[1]  = 1'b1;
        do_scan(1, 4'b0110, 4'b0110, 4, -1, 1'b0);
        chan[1] = 4'b1001;
        sb.push_back(4'b1001);
        @(posedge clk); #1;
        check("cont_valid_drop", int'(fv[1]), 0);
        n = 0;
        bad = (busy[1] != 1'b1);
        while (!fv[1] && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!busy[1]) bad = 1'b1;
        end
        check("cont_latency", n, 4);
        check("cont_no_idle", int'(bad), 0);
        check("cont_frame", int'(frm[1]), int'(sb.pop_front()));
        cont[1] = 1'b0;
        @(posedge clk); #1;
        check("cont_stop_idle", int'(busy[1]), 0);

        // Overrun: start while busy, then clear, then clear+set together.
        ready[0] = 1'b1;
        cont[0]  = 1'b0;
        do_scan(0, 4'b0011, 4'b0011, 8, 2, 1'b0);
        check("ovr_set", int'(ovr[0]), 1);
        @(posedge clk); #1;
        check("ovr_sticky", int'({ovr[0], busy[0]}), int'(2'b10));
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        check("ovr_clear", int'(ovr[0]), 0);
        do_scan(0, 4'b0110, 4'b0110, 8, 3, 1'b1);
        check("ovr_set_wins", int'(ovr[0]), 1);
        @(posedge clk); #1;
        clr[0] = 1'b1;
        @(posedge clk); #1;
        clr[0] = 1'b0;
        check("ovr_clear2", int'(ovr[0]), 0);

        // Asynchronous reset during channel 2 settle.
        chan[0]  = 4'b1111;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("pre_reset_sel", int'(sel[0]), 2);
        rst_n = 1'b0;
        #1;
        check("async_reset", int'({sel[0], frm[0], fv[0], busy[0]}), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (fv[0] || busy[0]) bad = 1'b1;
        end
        check("no_frame_after_reset", int'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
